// File: rtl/pwm_sched_pkg.sv
// Shared types and constants for the PWM duty-cycle scheduler.
package pwm_sched_pkg;

    typedef enum logic [1:0] {IDLE, SLEW, SETTLE} sched_state_t;

    typedef logic [7:0] duty_t;

    localparam duty_t PCNT_MAX = 8'hFF;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; the requester not served last wins a tie.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       en,
    input  logic       last,   // 1: requester 1 was granted last
    output logic [1:0] grant
);

    assign grant[0] = en & req[0] & (~req[1] | last);
    assign grant[1] = en & req[1] & (~req[0] | ~last);

endmodule

// File: rtl/pwm_duty_sched.sv
// Shares one PWM duty input between two requesters, slewing changes at period
// boundaries in bounded steps and reporting completion after a settle wait.
module pwm_duty_sched
    import pwm_sched_pkg::*;
#(
    parameter int STEP           = 8,
    parameter int SETTLE_PERIODS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       a_valid,
    input  logic [7:0] a_duty,
    output logic       a_ready,
    input  logic       b_valid,
    input  logic [7:0] b_duty,
    output logic       b_ready,
    output logic [7:0] duty,
    output logic       busy,
    output logic       grant_b,
    output logic       done
);

    sched_state_t      state, state_nxt;
    duty_t             pcnt;
    duty_t             target;
    duty_t             req_duty;
    logic [7:0]        settle_cnt;
    logic              last_b;
    logic              wrap;
    logic [1:0]        grant;
    logic signed [8:0] diff;
    logic [8:0]        mag;
    logic              final_step;
    logic              settle_last;

    rr_arb2 u_arb (
        .req   ({b_valid, a_valid}),
        .en    (state == IDLE),
        .last  (last_b),
        .grant (grant)
    );

    assign a_ready  = grant[0];
    assign b_ready  = grant[1];
    assign req_duty = grant[1] ? b_duty : a_duty;
    assign busy     = (state != IDLE);
    assign wrap     = (pcnt == PCNT_MAX);

    // 9-bit signed difference keeps the step direction and size free of 8-bit wrap.
    assign diff        = $signed({1'b0, target}) - $signed({1'b0, duty});
    assign mag         = diff[8] ? 9'(-diff) : 9'(diff);
    assign final_step  = (mag <= 9'(STEP));
    assign settle_last = ({1'b0, settle_cnt} + 9'd1) == 9'(SETTLE_PERIODS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|grant) state_nxt = (req_duty == duty) ? SETTLE : SLEW;
            SLEW:    if (wrap && final_step) state_nxt = SETTLE;
            SETTLE:  if (wrap && settle_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt       <= '0;
            duty       <= '0;
            target     <= '0;
            grant_b    <= 1'b0;
            last_b     <= 1'b1;
            settle_cnt <= '0;
            done       <= 1'b0;
        end else begin
            pcnt <= pcnt + 8'd1;
            done <= (state == SETTLE) && wrap && settle_last;
            case (state)
                IDLE: begin
                    // Duty is never touched on the accept edge, even when it is a wrap.
                    if (|grant) begin
                        target     <= req_duty;
                        grant_b    <= grant[1];
                        last_b     <= grant[1];
                        settle_cnt <= '0;
                    end
                end
                SLEW: begin
                    if (wrap) begin
                        if (final_step) begin
                            duty       <= target;
                            settle_cnt <= '0;
                        end else if (diff[8]) begin
                            duty <= duty - 8'(STEP);
                        end else begin
                            duty <= duty + 8'(STEP);
                        end
                    end
                end
                SETTLE: begin
                    if (wrap) settle_cnt <= settle_cnt + 8'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_duty_sched.sv
// Randomized self-checking bench for pwm_duty_sched against a per-wrap duty model.
module tb_pwm_duty_sched;

    localparam int STEP = 8;
    localparam int SP   = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       a_valid = 1'b0, b_valid = 1'b0;
    logic [7:0] a_duty = '0, b_duty = '0;
    logic       a_ready, b_ready;
    logic [7:0] duty;
    logic       busy, grant_b, done;

    int         errors = 0;
    int         checks = 0;
    int         cur = 0;      // model: duty currently driven to the PWM
    logic [7:0] mp;           // model of the shared PWM period counter

    pwm_duty_sched #(.STEP(STEP), .SETTLE_PERIODS(SP)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .a_valid (a_valid),
        .a_duty  (a_duty),
        .a_ready (a_ready),
        .b_valid (b_valid),
        .b_duty  (b_duty),
        .b_ready (b_ready),
        .duty    (duty),
        .busy    (busy),
        .grant_b (grant_b),
        .done    (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) mp <= 8'd0;
        else        mp <= mp + 8'd1;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Full transaction: request, accept, per-wrap slew, settle, done pulse.
    task automatic do_move(input bit use_b, input int tgt, input string nm);
        int budget;
        logic rdy;
        int d;
        int exp_q[$];
        @(negedge clk);
        if (use_b) begin b_valid = 1'b1; b_duty = 8'(tgt); end
        else       begin a_valid = 1'b1; a_duty = 8'(tgt); end
        #1;
        rdy = use_b ? b_ready : a_ready;
        budget = 0;
        while (!rdy && budget < 3000) begin
            @(negedge clk); #1;
            rdy = use_b ? b_ready : a_ready;
            budget++;
        end
        checks++;
        if (!rdy) begin
            errors++;
            $display("FAIL %s ready: never asserted, required 1", nm);
            a_valid = 1'b0; b_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        a_valid = 1'b0; b_valid = 1'b0;
        checks++;
        if ({busy, grant_b, duty} !== {1'b1, use_b, 8'(cur)}) begin
            errors++;
            $display("FAIL %s accept: busy/grant_b/duty=%0d/%0d/%0d required 1/%0d/%0d",
                     nm, busy, grant_b, duty, use_b, cur);
        end
        d = cur;
        while (d != tgt) begin
            if (tgt > d) d = (tgt - d > STEP) ? d + STEP : tgt;
            else         d = (d - tgt > STEP) ? d - STEP : tgt;
            exp_q.push_back(d);
        end
        foreach (exp_q[i]) begin
            while (mp != 8'hFF) @(negedge clk);
            checks++;
            if (duty !== 8'(cur)) begin
                errors++;
                $display("FAIL %s pre_wrap%0d: duty=%0d required %0d", nm, i, duty, cur);
            end
            @(negedge clk);
            checks++;
            if (duty !== 8'(exp_q[i])) begin
                errors++;
                $display("FAIL %s wrap%0d: duty=%0d required %0d", nm, i, duty, exp_q[i]);
            end
            cur = exp_q[i];
        end
        for (int s = 1; s <= SP; s++) begin
            while (mp != 8'hFF) @(negedge clk);
            checks++;
            if ({done, busy} !== 2'b01) begin
                errors++;
                $display("FAIL %s settle%0d_pre: done/busy=%0d/%0d required 0/1", nm, s, done, busy);
            end
            @(negedge clk);
            checks++;
            if (s == SP) begin
                if ({done, busy, duty} !== {2'b10, 8'(cur)}) begin
                    errors++;
                    $display("FAIL %s done: done/busy/duty=%0d/%0d/%0d required 1/0/%0d",
                             nm, done, busy, duty, cur);
                end
            end else if (done !== 1'b0) begin
                errors++;
                $display("FAIL %s early_done%0d: done=%0d required 0", nm, s, done);
            end
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL %s done_pulse: done=%0d required 0", nm, done);
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        a_valid = 1'b0; b_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cur = 0;
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        checks++;
        if ({duty, busy, done, a_ready, b_ready} !== 12'd0) begin
            errors++;
            $display("FAIL reset: duty/busy/done/a_ready/b_ready=%0d/%0d/%0d/%0d/%0d required 0/0/0/0/0",
                     duty, busy, done, a_ready, b_ready);
        end
    endtask

    task automatic test_ramp();
        do_move(1'b0, 64, "ramp_0_64");
    endtask

    task automatic test_nonmult();
        do_move(1'b0, 20, "up_20");
        do_move(1'b1, 3, "down_3");
    endtask

    task automatic test_same();
        do_move(1'b0, 64, "to_64");
        do_move(1'b1, 64, "same_64");
    endtask

    // Both requesters held: A, then B in the done cycle, then A again.
    task automatic test_tie();
        int n;
        @(negedge clk);
        a_valid = 1'b1; a_duty = 8'(cur);
        b_valid = 1'b1; b_duty = 8'(cur);
        #1;
        checks++;
        if ({a_ready, b_ready} !== 2'b10) begin
            errors++;
            $display("FAIL tie1_ready: a/b=%0d/%0d required 1/0", a_ready, b_ready);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy, grant_b, a_ready, b_ready} !== 4'b1000) begin
            errors++;
            $display("FAIL tie1_grant: busy/grant_b/a/b=%0d/%0d/%0d/%0d required 1/0/0/0",
                     busy, grant_b, a_ready, b_ready);
        end
        for (int k = 0; k < 2; k++) begin
            n = 0;
            while (done !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
            checks++;
            if ({done, a_ready, b_ready} !== {1'b1, k == 1, k == 0}) begin
                errors++;
                $display("FAIL tie%0d_done_ready: done/a/b=%0d/%0d/%0d required 1/%0d/%0d",
                         k + 2, done, a_ready, b_ready, k == 1, k == 0);
            end
            @(posedge clk);
            @(negedge clk);
            checks++;
            if ({busy, grant_b, duty} !== {1'b1, k == 0, 8'(cur)}) begin
                errors++;
                $display("FAIL tie%0d_grant: busy/grant_b/duty=%0d/%0d/%0d required 1/%0d/%0d",
                         k + 2, busy, grant_b, duty, k == 0, cur);
            end
        end
        a_valid = 1'b0; b_valid = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL tie_final_done: done=%0d required 1", done);
        end
    endtask

    task automatic test_random();
        int t;
        for (int i = 0; i < 6; i++) begin
            t = cur + int'($urandom_range(0, 120)) - 60;
            if (t < 0)   t = 0;
            if (t > 255) t = 255;
            repeat ($urandom_range(0, 300)) @(negedge clk);
            do_move(1'($urandom_range(0, 1)), t, $sformatf("rand%0d", i));
        end
    endtask

    task automatic test_reset_mid();
        int n;
        apply_reset();
        a_valid = 1'b1; a_duty = 8'd200;
        #1;
        checks++;
        if (a_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_accept: a_ready=%0d required 1", a_ready);
        end
        @(posedge clk);
        @(negedge clk);
        a_valid = 1'b0;
        n = 0;
        while (duty != 8'd96 && n < 40) begin
            while (mp != 8'hFF) @(negedge clk);
            @(negedge clk);
            n++;
        end
        checks++;
        if ({duty, busy} !== {8'd96, 1'b1}) begin
            errors++;
            $display("FAIL mid_reach96: duty/busy=%0d/%0d required 96/1", duty, busy);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({duty, busy, done} !== 10'd0) begin
            errors++;
            $display("FAIL mid_async_reset: duty/busy/done=%0d/%0d/%0d required 0/0/0", duty, busy, done);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cur = 0;
        do_move(1'b0, 40, "after_reset");
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_nonmult();
        test_same();
        test_tie();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pwm_duty_sched.md
# pwm_duty_sched

Duty-cycle scheduler for the 8-bit PWM used by the logic analyzer's filtered analog outputs, e.g. threshold and offset DACs. It shares the single PWM duty input between two requesters through round-robin arbitration. Duty changes are applied only at PWM period boundaries, slewed in bounded steps to limit ripple on the downstream RC filter. After the target is reached, the block waits a fixed number of settle periods and then reports completion.

## Interface
- STEP, default 8: maximum duty change per PWM period; legal range 1..255.
- SETTLE_PERIODS, default 4: full PWM periods to wait after the target is reached; legal range 1..255.

- clk  in  1  clock; same clock as the PWM.
- rst_n  in  1  reset: rst_n, asynchronous, active-low; clock clk.
- a_valid  in  1  requester A holds a new target.
- a_duty  in  8  requester A target duty; must stay stable while a_valid && !a_ready.
- a_ready  out  1  requester A target accepted this cycle.
- b_valid, b_duty, b_ready: same as the A signals, for requester B.
- duty  out  8  registered duty value driven to the PWM.
- busy  out  1  a transaction is in progress (SLEW or SETTLE).
- grant_b  out  1  requester being served: 0 = A, 1 = B; valid while busy.
- done  out  1  one-cycle pulse at the end of settling.

## Operation
- Internal 8-bit period counter `pcnt`:
  - Reset value 0; increments every clk and wraps 255→0.
  - It is bit-identical to the PWM's own counter, because both leave reset together.
  - `wrap` = (pcnt == 8'hFF).
- States: IDLE, SLEW, SETTLE.
- IDLE:
  - a_ready = IDLE && a_valid && (!b_valid || last_b).
  - b_ready = IDLE && b_valid && (!a_valid || !last_b).
  - Readies are combinational; the handshake completes on valid && ready.
  - On accept: latch target, set grant_b, set last_b = grant_b.
  - If target == duty, go to SETTLE; otherwise go to SLEW.
- SLEW, on each `wrap` edge:
  - diff = target − duty, computed in 9-bit signed arithmetic.
  - If |diff| ≤ STEP: duty ← target, go to SETTLE.
  - Otherwise: duty ← duty ± STEP, toward the target.
  - No 8-bit wrap-around: duty never overshoots and never leaves 0..255.
- SETTLE:
  - Settle counter loads 0 on entry and increments on each `wrap` edge.
  - On the wrap edge where the counter reaches SETTLE_PERIODS: done = 1 for one cycle, busy → 0, go to IDLE.
- Requests are never accepted outside IDLE. A requester keeps valid asserted; there is no abort.
- Reset values: duty = 0, busy = 0, done = 0, grant_b = 0, last_b = 1 (A wins the first tie), state = IDLE, pcnt = 0, settle counter = 0.
- Reset asserted mid-transaction:
  - Everything returns immediately to the reset values; the latched target is discarded.
  - A requester whose ready never fired must re-present its target after reset.

## Timing
- Accept edge: busy = 1 from the next cycle. duty is not modified on the accept edge, even if that cycle is a `wrap` cycle.
- First duty step: on the first `wrap` edge strictly after acceptance. The PWM sees the new duty starting at its counter value 0.
- Period structure:
  - Slew takes ceil(|target − start| / STEP) wraps.
  - Settle takes SETTLE_PERIODS further wraps.
  - Each wrap is 256 clk.
- done is asserted in the cycle after the final wrap edge; that cycle is also the first IDLE cycle. A ready may assert in that same cycle.
- A request with target equal to the current duty still incurs the full SETTLE_PERIODS wait and produces a done pulse.

## Structure
- Package `pwm_sched_pkg`:
  - `sched_state_t` enum {IDLE, SLEW, SETTLE}.
  - Localparam `PCNT_MAX = 8'hFF`.
  - 8-bit duty typedef `duty_t`.
- Sub-module `rr_arb2`:
  - Two-requester round-robin arbiter.
  - Inputs: req[1:0], en, last.
  - Output: grant one-hot.
  - Purely combinational; the last-grant flop stays in the top level.
- Top level: period counter, FSM, slew datapath, settle counter.

## Test plan
- Reset: hold rst_n low for 3 cycles, then release → duty = 0, busy = 0, done = 0, both readies 0 with no valid. pcnt reaches 255 at cycle 255 after release.
- A request 0→64 with STEP = 8, SETTLE_PERIODS = 4 → duty is 8, 16, …, 64 on 8 successive wraps. done is pulsed one cycle after the 12th wrap. duty changes only when pcnt rolls to 0.
- Non-multiple and downward moves: target 20 from 0 gives duty 8, 16, 20. Then target 3 from 20 gives 12, 4, 3. duty never goes below 3.
- Simultaneous a_valid and b_valid, both held → A is accepted first (grant_b = 0), then B is accepted in the done cycle (grant_b = 1). A third tie is granted to A.
- Request with target equal to the current duty of 64 → no duty change. done follows after exactly 4 wraps.
- Reset asserted midway through a 0→200 slew, at duty = 96 → duty = 0 and busy = 0 asynchronously. After release, a new request restarts the slew from 0.
